// File: rtl/accel_pkg.sv
// Shared widths and field layouts for the backward-search accelerator.
package accel_pkg;
    localparam int ADDR_W      = 12;
    localparam int INEXRECUR_W = 32;
    localparam int STATE_W     = 18;

    typedef struct packed {
        logic [7:0] i;
        logic [7:0] z;
        logic [7:0] k;
        logic [7:0] l;
    } param_t;

    localparam int POS_LSB = 0;
    localparam int POS_W   = 5;
endpackage

// File: rtl/regfile_2w1r.sv
// W x DEPTH storage, two write ports (port B wins on a collision), one registered read port.
module regfile_2w1r #(
    parameter int W      = 32,
    parameter int DEPTH  = 256,
    parameter int AW     = 8,
    parameter bit BYPASS = 1'b0
) (
    input  logic          clk,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [W-1:0]  wdata_a,
    input  logic          we_b,
    input  logic [AW-1:0] addr_b,
    input  logic [W-1:0]  wdata_b,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= wdata_a;
        if (we_b) mem[addr_b] <= wdata_b;
        if (re) begin
            // Write-first forwarding mirrors the B-over-A write priority.
            if (BYPASS && we_b && addr_b == raddr)      rdata <= wdata_b;
            else if (BYPASS && we_a && addr_a == raddr) rdata <= wdata_a;
            else                                        rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/inexrecur_state_regfile.sv
// Paired InexRecur/state work-list storage with scan, random read, append and in-place update.
// Optional REGFILE_BYPASS_EN selects write-first reads; default is read-first.
module inexrecur_state_regfile
    import accel_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   init_we,
    input  logic [INEXRECUR_W-1:0] init_data,
    input  logic                   re_seq_i,
    input  logic                   re_ran_i,
    input  logic [ADDR_W-1:0]      r_addr_i,
    input  logic                   seq_we_i,
    input  logic [INEXRECUR_W-1:0] seq_w_inexrecur_i,
    input  logic [STATE_W-1:0]     seq_w_state_i,
    input  logic                   ran_we_inexrecur_i,
    input  logic                   ran_we_state_i,
    input  logic [ADDR_W-1:0]      ran_w_addr_inexrecur_i,
    input  logic [ADDR_W-1:0]      ran_w_addr_state_i,
    input  logic [INEXRECUR_W-1:0] ran_w_data_inexrecur_i,
    input  logic [STATE_W-1:0]     ran_w_data_state_i,
    output logic [ADDR_W-1:0]      inexrecur_addr_o,
    output logic [ADDR_W-1:0]      state_addr_o,
    output logic [INEXRECUR_W-1:0] inexrecur_data_o,
    output logic [STATE_W-1:0]     state_data_o,
    output logic                   rd_valid_o,
    output logic                   scan_wrap_o,
    output logic [12:0]            count_o,
    output logic                   full_o,
    output logic                   overflow_o
);
    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [12:0] DEPTH13 = 13'(DEPTH);
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [12:0]            cnt, ptr_nxt;
    logic [ADDR_W-1:0]      rd_ptr, addr_q, rd_addr;
    logic                   ovf, vld_q, wrap_q, hit_q;
    logic                   is_full, live, app_ok, ir_ok, st_ok, rd_req, rd_hit, seq_adv, seq_wrap;
    logic                   we_a;
    logic [AW-1:0]          addr_a;
    logic [INEXRECUR_W-1:0] ir_wa, ir_rdata;
    logic [STATE_W-1:0]     st_wa, st_rdata;
    param_t                 seed;

    assign seed    = param_t'(init_data);
    assign is_full = (cnt == DEPTH13);
    assign live    = !rst && !init_we;
    assign app_ok  = live && seq_we_i && !is_full;
    // An in-place write may target the slot appended in the same cycle, and then wins.
    assign ir_ok   = live && ran_we_inexrecur_i &&
                     (({1'b0, ran_w_addr_inexrecur_i} < cnt) || (app_ok && {1'b0, ran_w_addr_inexrecur_i} == cnt));
    assign st_ok   = live && ran_we_state_i &&
                     (({1'b0, ran_w_addr_state_i} < cnt) || (app_ok && {1'b0, ran_w_addr_state_i} == cnt));

    assign rd_req   = live && (re_seq_i || re_ran_i);
    assign rd_addr  = re_ran_i ? r_addr_i : rd_ptr;
    assign rd_hit   = ({1'b0, rd_addr} < cnt) || (BYPASS && app_ok && {1'b0, rd_addr} == cnt);
    assign seq_adv  = live && re_seq_i && !re_ran_i && (cnt != 13'd0);
    assign ptr_nxt  = {1'b0, rd_ptr} + 13'd1;
    assign seq_wrap = (ptr_nxt >= cnt);

    // Port A carries both the host seed (entry 0) and appends.
    assign we_a   = (init_we && !rst) || app_ok;
    assign addr_a = init_we ? '0 : cnt[AW-1:0];
    assign ir_wa  = init_we ? seed : seq_w_inexrecur_i;
    assign st_wa  = init_we ? '0 : seq_w_state_i;

    regfile_2w1r #(.W(INEXRECUR_W), .DEPTH(DEPTH), .AW(AW), .BYPASS(BYPASS)) u_ir (
        .clk(clk), .we_a(we_a), .addr_a(addr_a), .wdata_a(ir_wa),
        .we_b(ir_ok), .addr_b(ran_w_addr_inexrecur_i[AW-1:0]), .wdata_b(ran_w_data_inexrecur_i),
        .re(rd_req), .raddr(rd_addr[AW-1:0]), .rdata(ir_rdata)
    );

    regfile_2w1r #(.W(STATE_W), .DEPTH(DEPTH), .AW(AW), .BYPASS(BYPASS)) u_st (
        .clk(clk), .we_a(we_a), .addr_a(addr_a), .wdata_a(st_wa),
        .we_b(st_ok), .addr_b(ran_w_addr_state_i[AW-1:0]), .wdata_b(ran_w_data_state_i),
        .re(rd_req), .raddr(rd_addr[AW-1:0]), .rdata(st_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            rd_ptr <= '0;
            addr_q <= '0;
            ovf    <= 1'b0;
            vld_q  <= 1'b0;
            wrap_q <= 1'b0;
            hit_q  <= 1'b0;
        end else if (init_we) begin
            cnt    <= 13'd1;
            rd_ptr <= '0;
            ovf    <= 1'b0;
            vld_q  <= 1'b0;
            wrap_q <= 1'b0;
            hit_q  <= 1'b0;
        end else begin
            if (seq_we_i && is_full) ovf <= 1'b1;
            if (app_ok)              cnt <= cnt + 13'd1;
            vld_q  <= rd_req;
            hit_q  <= rd_req && rd_hit;
            wrap_q <= seq_adv && seq_wrap;
            if (rd_req)  addr_q <= rd_addr;
            if (seq_adv) rd_ptr <= seq_wrap ? '0 : ptr_nxt[ADDR_W-1:0];
        end
    end

    // Stale array data is masked by the registered hit flag.
    assign inexrecur_data_o = hit_q ? ir_rdata : '0;
    assign state_data_o     = hit_q ? st_rdata : '0;
    assign inexrecur_addr_o = addr_q;
    assign state_addr_o     = addr_q;
    assign rd_valid_o       = vld_q;
    assign scan_wrap_o      = wrap_q;
    assign count_o          = cnt;
    assign full_o           = is_full;
    assign overflow_o       = ovf;
endmodule
